fp_to_gp_wb_buffer: RTL and testbench



---
 rtl/fp_to_gp_wb_buffer.sv | 83 ++++++++
 tb/tb_fp_to_gp_wb_buffer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fp_to_gp_wb_buffer.sv
// Writeback decoupling FIFO between the FP-to-GP unit and the integer writeback arbiter.
// Every output is driven from registered state, so the arbiter's ack never reaches the unit's ack.
module fp_to_gp_wb_buffer #(
  parameter int DEPTH      = 2,
  parameter int ID_WIDTH   = 3,
  parameter int DATA_WIDTH = 32,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_done,
  input  logic [ID_WIDTH-1:0]   in_id,
  input  logic [DATA_WIDTH-1:0] in_rd,
  output logic                  in_ack,
  output logic                  wb_done,
  output logic [ID_WIDTH-1:0]   wb_id,
  output logic [DATA_WIDTH-1:0] wb_rd,
  input  logic                  wb_ack,
  output logic [CNT_W-1:0]      occupancy
);

  logic [CNT_W-1:0]      r_count;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [ID_WIDTH-1:0]   r_id_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_mem [DEPTH];

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Full and empty come from the count alone; the pointers simply wrap.
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  assign in_ack    = !rst && !w_full;
  assign wb_done   = !w_empty;
  assign wb_id     = r_id_mem[r_rd_ptr];
  assign wb_rd     = r_rd_mem[r_rd_ptr];
  assign occupancy = r_count;

  assign w_push = in_done && in_ack;
  assign w_pop  = wb_done && wb_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_id_mem[i] <= '0;
        r_rd_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_id_mem[r_wr_ptr] <= in_id;
        r_rd_mem[r_wr_ptr] <= in_rd;
        r_wr_ptr           <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(w_push && w_full)) else $error("push into full buffer");
      assert (!(w_pop && w_empty)) else $error("pop from empty buffer");
      assert (r_count <= CNT_W'(DEPTH)) else $error("count exceeds depth");
    end
  end
`endif

endmodule

// File: tb/tb_fp_to_gp_wb_buffer.sv
// Bench for fp_to_gp_wb_buffer: directed scenarios plus a random stall run against a queue model.
module tb_fp_to_gp_wb_buffer;

  localparam int DEPTH      = 2;
  localparam int ID_WIDTH   = 3;
  localparam int DATA_WIDTH = 32;
  localparam int CNT_W      = $clog2(DEPTH) + 1;

  logic                  clk;
  logic                  rst;
  logic                  in_done;
  logic [ID_WIDTH-1:0]   in_id;
  logic [DATA_WIDTH-1:0] in_rd;
  logic                  in_ack;
  logic                  wb_done;
  logic [ID_WIDTH-1:0]   wb_id;
  logic [DATA_WIDTH-1:0] wb_rd;
  logic                  wb_ack;
  logic [CNT_W-1:0]      occupancy;

  fp_to_gp_wb_buffer #(
    .DEPTH(DEPTH), .ID_WIDTH(ID_WIDTH), .DATA_WIDTH(DATA_WIDTH)
  ) dut (
    .clk(clk), .rst(rst),
    .in_done(in_done), .in_id(in_id), .in_rd(in_rd), .in_ack(in_ack),
    .wb_done(wb_done), .wb_id(wb_id), .wb_rd(wb_rd), .wb_ack(wb_ack),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: results held in arrival order, {id, rd} per entry.
  logic [ID_WIDTH+DATA_WIDTH-1:0] model_q[$];
  bit last_push;
  int n_pushed;
  int n_popped;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: apply model rules to the stimulus in place, then compare all outputs after the edge.
  task automatic cycle();
    bit m_push;
    bit m_pop;
    m_push = in_done && !rst && (model_q.size() < DEPTH);
    m_pop  = wb_ack && (model_q.size() != 0);
    if (m_pop) begin
      void'(model_q.pop_front());
      n_popped++;
    end
    if (m_push) begin
      model_q.push_back({in_id, in_rd});
      n_pushed++;
    end
    if (rst) begin
      model_q.delete();
      n_pushed = 0;
      n_popped = 0;
    end
    last_push = m_push;
    @(posedge clk);
    #1;
    check("in_ack", 64'(in_ack), 64'(!rst && (model_q.size() != DEPTH)));
    check("wb_done", 64'(wb_done), 64'(model_q.size() != 0));
    check("occupancy", 64'(occupancy), 64'(n_pushed - n_popped));
    if (model_q.size() != 0) begin
      check("wb_id", 64'(wb_id), 64'(model_q[0][ID_WIDTH+DATA_WIDTH-1:DATA_WIDTH]));
      check("wb_rd", 64'(wb_rd), 64'(model_q[0][DATA_WIDTH-1:0]));
    end
  endtask

  initial begin
    rst = 1'b1; in_done = 1'b0; in_id = '0; in_rd = '0; wb_ack = 1'b0;
    last_push = 1'b0; n_pushed = 0; n_popped = 0;

    // Reset then idle
    #1;
    check("reset_in_ack", 64'(in_ack), 64'(0));
    cycle();
    cycle();
    rst = 1'b0;
    #1;
    check("post_reset_in_ack", 64'(in_ack), 64'(1));
    check("post_reset_wb_done", 64'(wb_done), 64'(0));
    check("post_reset_occ", 64'(occupancy), 64'(0));

    // Single result
    in_done = 1'b1; in_id = 3'd5; in_rd = 32'h7FFF_FFFF; wb_ack = 1'b1;
    cycle();
    in_done = 1'b0;
    check("single_done", 64'(wb_done), 64'(1));
    check("single_id", 64'(wb_id), 64'(5));
    check("single_rd", 64'(wb_rd), 64'h7FFF_FFFF);
    cycle();
    check("single_drained", 64'(wb_done), 64'(0));

    // Fill to full, hold a third result until one pop frees a slot
    wb_ack = 1'b0;
    in_done = 1'b1; in_id = 3'd1; in_rd = 32'h8000_0000;
    cycle();
    in_id = 3'd2; in_rd = 32'h0000_0001;
    cycle();
    check("full_occ", 64'(occupancy), 64'(2));
    check("full_in_ack", 64'(in_ack), 64'(0));
    in_id = 3'd3; in_rd = 32'h0000_0003;
    cycle();
    check("held_occ", 64'(occupancy), 64'(2));
    check("held_head", 64'(wb_id), 64'(1));
    wb_ack = 1'b1;
    cycle();
    check("after_pop_ack", 64'(in_ack), 64'(1));
    check("after_pop_head", 64'(wb_id), 64'(2));
    wb_ack = 1'b0;
    cycle();
    check("third_in_occ", 64'(occupancy), 64'(2));
    in_done = 1'b0; wb_ack = 1'b1;
    cycle();
    check("order_3_id", 64'(wb_id), 64'(3));
    check("order_3_rd", 64'(wb_rd), 64'h3);
    cycle();

    // Back-to-back streaming with the arbiter always ready
    for (int i = 0; i < 8; i++) begin
      in_done = 1'b1; in_id = ID_WIDTH'(i); in_rd = 32'(i) * 32'h1111_1111;
      cycle();
      check("stream_occ", 64'(occupancy), 64'(1));
      check("stream_id", 64'(wb_id), 64'(i));
      check("stream_in_ack", 64'(in_ack), 64'(1));
    end
    in_done = 1'b0;
    cycle();

    // Random producer/arbiter traffic; the producer holds a result until it is taken
    last_push = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (!in_done || last_push) begin
        in_done = ($urandom_range(0, 3) != 0);
        in_id   = ID_WIDTH'($urandom);
        in_rd   = $urandom;
      end
      wb_ack = ($urandom_range(0, 2) != 0);
      cycle();
    end
    in_done = 1'b0; wb_ack = 1'b1;
    repeat (3) cycle();

    // Reset mid-operation discards both buffered entries
    wb_ack = 1'b0;
    in_done = 1'b1; in_id = 3'd6; in_rd = 32'hDEAD_BEEF;
    cycle();
    in_id = 3'd7; in_rd = 32'hCAFE_F00D;
    cycle();
    check("pre_reset_occ", 64'(occupancy), 64'(2));
    in_done = 1'b0; rst = 1'b1;
    cycle();
    check("mid_reset_done", 64'(wb_done), 64'(0));
    check("mid_reset_occ", 64'(occupancy), 64'(0));
    rst = 1'b0; wb_ack = 1'b1;
    repeat (3) begin
      cycle();
      check("no_stale_done", 64'(wb_done), 64'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
